// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one single-port memory between instruction fetch and
// load/store, one outstanding transaction, data priority with a fetch starvation guard.
module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [1:0]        m_size,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ready,
  input  logic              m_rvalid,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              err
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} stateT;

  stateT       state;
  logic        owner;
  logic [3:0]  starve;
  logic        reqRaw;
  logic        selData;
  logic        reqLive;
  logic        respOk;

  // Winner selection: fresh arbitration in IDLE, locked to owner in ISSUE.
  always_comb begin
    reqRaw  = 1'b0;
    selData = 1'b0;
    case (state)
      IDLE: begin
        reqRaw  = if_req | d_req;
        selData = d_req & (~if_req | (starve < 4'(MAX_WAIT)));
      end
      ISSUE: begin
        reqRaw  = 1'b1;
        selData = owner;
      end
      WAIT: begin
        reqRaw  = 1'b0;
        selData = owner;
      end
      default: begin
        reqRaw  = 1'b0;
        selData = 1'b0;
      end
    endcase
  end

  // Memory-side muxing and requester handshakes; fields are zeroed while idle.
  always_comb begin
    reqLive = reqRaw & ~rst;
    respOk  = ~rst & (state == WAIT) & m_rvalid;
    m_req   = reqLive;
    if (!reqLive) begin
      m_we    = 1'b0;
      m_size  = 2'b00;
      m_addr  = '0;
      m_wdata = '0;
    end else if (selData) begin
      m_we    = d_we;
      m_size  = d_size;
      m_addr  = d_addr;
      m_wdata = d_wdata;
    end else begin
      m_we    = 1'b0;
      m_size  = 2'b10;
      m_addr  = if_addr;
      m_wdata = '0;
    end
    if_gnt    = reqLive & m_ready & ~selData;
    d_gnt     = reqLive & m_ready & selData;
    if_rvalid = respOk & ~owner;
    d_rvalid  = respOk & owner;
    if_rdata  = m_rdata;
    d_rdata   = m_rdata;
  end

  // Sequencer state, starvation counter and sticky stray-response flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      owner  <= 1'b0;
      starve <= 4'd0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (reqRaw) begin
            owner <= selData;
            state <= m_ready ? WAIT : ISSUE;
          end
        end
        ISSUE: if (m_ready) state <= WAIT;
        WAIT:  if (m_rvalid) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (!if_req || if_gnt) begin
        starve <= 4'd0;
      end else if (d_gnt && starve != 4'd15) begin
        starve <= starve + 4'd1;
      end

      // A response with nothing outstanding is dropped and latched as an error.
      if (m_rvalid && state != WAIT) err <= 1'b1;
    end
  end

endmodule
